// File: rtl/dmem_responder_pkg.sv
// Shared constants for the MEM-stage data-memory responder: MMIO window
// layout and the read FSM state encoding.
package dmem_responder_pkg;

    localparam logic [15:0] MMIO_BASE = 16'hFFFF;
    localparam logic [15:0] LED_OFS   = 16'h0000;
    localparam logic [15:0] SW_OFS    = 16'h0004;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage memory port between the pipeline (master) and the data-memory
// responder (slave).
interface dmem_responder_if;

    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic [31:0] mem_din;
    logic        mem_stall;

    modport master (
        output mem_ren, mem_wen, mem_addr, mem_dout,
        input  mem_din, mem_stall
    );

    modport slave (
        input  mem_ren, mem_wen, mem_addr, mem_dout,
        output mem_din, mem_stall
    );

endinterface

// File: rtl/dmem_ram.sv
// Single-port synchronous word RAM with a one-cycle registered read.
// Contents are intentionally not reset.
module dmem_ram #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: address decode, one-entry posted write
// buffer in front of a synchronous RAM, LED/switch MMIO and the read FSM.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    dmem_responder_if.slave         mem,
    input  logic [15:0]             sw,
    output logic [15:0]             led
);

    state_t                  state, state_nxt;
    logic                    wbuf_valid;
    logic [ADDR_WIDTH-1:0]   wbuf_addr;
    logic [31:0]             wbuf_data;
    logic [15:0]             sw_meta, sw_sync;

    logic                    is_mmio, rd_req, wr_req, wbuf_hit;
    logic                    ram_rd, ram_we;
    logic [15:0]             mmio_ofs;
    logic [ADDR_WIDTH-1:0]   word_addr, ram_addr;
    logic [31:0]             ram_rdata;

    // A simultaneous read and write request is handled purely as a write.
    assign is_mmio   = (mem.mem_addr[31:16] == MMIO_BASE);
    assign mmio_ofs  = mem.mem_addr[15:0];
    assign word_addr = mem.mem_addr[ADDR_WIDTH+1:2];
    assign wr_req    = mem.mem_wen;
    assign rd_req    = mem.mem_ren & ~mem.mem_wen;
    assign wbuf_hit  = wbuf_valid & (wbuf_addr == word_addr);

    // The buffered entry drains on any cycle the RAM port is not reading.
    assign ram_we   = wbuf_valid & ~ram_rd;
    assign ram_addr = ram_rd ? word_addr : wbuf_addr;

    dmem_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wbuf_data),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        ram_rd        = 1'b0;
        mem.mem_stall = 1'b0;
        mem.mem_din   = 32'h0;
        case (state)
            IDLE: begin
                if (rd_req) begin
                    if (is_mmio) begin
                        if (mmio_ofs == LED_OFS)
                            mem.mem_din = {16'h0, led};
                        else if (mmio_ofs == SW_OFS)
                            mem.mem_din = {16'h0, sw_sync};
                    end else if (wbuf_hit) begin
                        mem.mem_din = wbuf_data;
                    end else begin
                        ram_rd        = 1'b1;
                        mem.mem_stall = 1'b1;
                        state_nxt     = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                mem.mem_din = ram_rdata;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A new RAM store takes priority over clearing the entry that drains now.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbuf_valid <= 1'b0;
            wbuf_addr  <= '0;
            wbuf_data  <= 32'h0;
        end else if (wr_req && !is_mmio) begin
            wbuf_valid <= 1'b1;
            wbuf_addr  <= word_addr;
            wbuf_data  <= mem.mem_dout;
        end else if (ram_we) begin
            wbuf_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led     <= 16'h0;
            sw_meta <= 16'h0;
            sw_sync <= 16'h0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
            if (wr_req && is_mmio && (mmio_ofs == LED_OFS))
                led <= mem.mem_dout[15:0];
        end
    end

endmodule
